// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared state encodings for the push-button debouncer
// Purpose: per-channel FSM state type used by btn_debounce_ch.
//   S_LOW  : stable low level
//   S_RISE : qualifying a low->high change
//   S_HIGH : stable high level
//   S_FALL : qualifying a high->low change
// Ports: none (package).
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_RISE = 2'b01,
    S_HIGH = 2'b11,
    S_FALL = 2'b10
  } db_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one debounce channel: 2-flop synchroniser, qualify counter, FSM
// Purpose: brings one raw asynchronous button level into clk and only lets db_out follow
//   a new level after it has been seen for STABLE_CYCLES consecutive cycles.
// Ports:
//   clk      in   system clock, posedge
//   rst_n    in   synchronous reset, active-low
//   raw      in   raw asynchronous button level, active-high
//   db_out   out  debounced level (registered)
//   bouncing out  1 while a candidate change is being qualified (registered)
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db_out,
  output logic bouncing
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  db_state_e        state;

  // Synchroniser: the FSM only ever looks at sync2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Qualify FSM. Outputs are updated together with the state so they are
  // plain flop outputs and can never glitch. The counter is only non-zero
  // while in S_RISE/S_FALL and stops at CNT_LAST, where the state moves on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_LOW;
      cnt      <= CNT_ZERO;
      db_out   <= 1'b0;
      bouncing <= 1'b0;
    end else begin
      case (state)
        S_LOW: begin
          cnt <= CNT_ZERO;
          if (sync2) begin
            state    <= S_RISE;
            bouncing <= 1'b1;
          end
        end
        S_RISE: begin
          if (!sync2) begin
            // Opposite level during qualification: drop the candidate.
            state    <= S_LOW;
            cnt      <= CNT_ZERO;
            bouncing <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state    <= S_HIGH;
            cnt      <= CNT_ZERO;
            db_out   <= 1'b1;
            bouncing <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HIGH: begin
          cnt <= CNT_ZERO;
          if (!sync2) begin
            state    <= S_FALL;
            bouncing <= 1'b1;
          end
        end
        S_FALL: begin
          if (sync2) begin
            state    <= S_HIGH;
            cnt      <= CNT_ZERO;
            bouncing <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state    <= S_LOW;
            cnt      <= CNT_ZERO;
            db_out   <= 1'b0;
            bouncing <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a known released button.
          state    <= S_LOW;
          cnt      <= CNT_ZERO;
          db_out   <= 1'b0;
          bouncing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - multi-channel push-button debouncer top
// Purpose: N_BTN independent debounce channels; feeds the edge-to-pulse stage.
// Ports:
//   clk      in   [1]      system clock, posedge
//   rst_n    in   [1]      synchronous reset, active-low
//   btn_raw  in   [N_BTN]  raw asynchronous button levels, active-high
//   db_out   out  [N_BTN]  debounced level per channel
//   bouncing out  [N_BTN]  1 while channel i is qualifying a candidate change
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int N_BTN         = 1,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] db_out,
  output logic [N_BTN-1:0] bouncing
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw     (btn_raw[i]),
      .db_out  (db_out[i]),
      .bouncing(bouncing[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - self-checking bench for btn_debounce (N_BTN=2, STABLE_CYCLES=4)
module tb_btn_debounce;

  localparam int N_BTN         = 2;
  localparam int STABLE_CYCLES = 4;

  logic             clk;
  logic             rst_n;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] db_out;
  logic [N_BTN-1:0] bouncing;

  int checks;
  int errors;

  typedef struct {
    logic       rst_n;
    logic [1:0] raw;
    logic [1:0] exp_db;
    logic [1:0] exp_bn;
    string      name;
  } vec_t;

  vec_t vecs[$];

  btn_debounce #(
    .N_BTN        (N_BTN),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .db_out  (db_out),
    .bouncing(bouncing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Append n identical cycles to the vector table.
  task automatic add(input logic r, input logic [1:0] raw, input logic [1:0] db,
                     input logic [1:0] bn, input int n, input string name);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst_n  = r;
      v.raw    = raw;
      v.exp_db = db;
      v.exp_bn = bn;
      v.name   = name;
      vecs.push_back(v);
    end
  endtask

  // Advance past one posedge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [1:0] exp_db, input logic [1:0] exp_bn);
    checks++;
    if (db_out !== exp_db || bouncing !== exp_bn) begin
      errors++;
      $display("FAIL %s[%0d]: db_out=%b bouncing=%b, expected db_out=%b bouncing=%b",
               name, idx, db_out, bouncing, exp_db, exp_bn);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    btn_raw = 2'b00;

    // 1. reset held with buttons pressed
    add(1'b0, 2'b11, 2'b00, 2'b00, 10, "reset_hold");
    add(1'b1, 2'b00, 2'b00, 2'b00, 3,  "idle");
    // 2. clean press ch0 (first entry = sample edge k)
    add(1'b1, 2'b01, 2'b00, 2'b00, 2, "press_sync");
    add(1'b1, 2'b01, 2'b00, 2'b01, 4, "press_qual");
    add(1'b1, 2'b01, 2'b01, 2'b00, 2, "press_done");
    // clean release ch0
    add(1'b1, 2'b00, 2'b01, 2'b00, 2, "rel_sync");
    add(1'b1, 2'b00, 2'b01, 2'b01, 4, "rel_qual");
    add(1'b1, 2'b00, 2'b00, 2'b00, 2, "rel_done");
    // 3. bounce on ch0: raw 1,1,0,1,1,1,...
    add(1'b1, 2'b01, 2'b00, 2'b00, 2, "bounce_a");
    add(1'b1, 2'b00, 2'b00, 2'b01, 1, "bounce_b");
    add(1'b1, 2'b01, 2'b00, 2'b01, 1, "bounce_c");
    add(1'b1, 2'b01, 2'b00, 2'b00, 1, "bounce_drop");
    add(1'b1, 2'b01, 2'b00, 2'b01, 4, "bounce_requal");
    add(1'b1, 2'b01, 2'b01, 2'b00, 2, "bounce_done");
    // 5. release with one-cycle re-press at m+3: raw 0,0,0,1,0,0,...
    add(1'b1, 2'b00, 2'b01, 2'b00, 2, "repress_a");
    add(1'b1, 2'b00, 2'b01, 2'b01, 1, "repress_b");
    add(1'b1, 2'b01, 2'b01, 2'b01, 1, "repress_c");
    add(1'b1, 2'b00, 2'b01, 2'b01, 1, "repress_d");
    add(1'b1, 2'b00, 2'b01, 2'b00, 1, "repress_back");
    add(1'b1, 2'b00, 2'b01, 2'b01, 4, "repress_requal");
    add(1'b1, 2'b00, 2'b00, 2'b00, 2, "repress_done");
    // 4. three-cycle glitch on ch1
    add(1'b1, 2'b10, 2'b00, 2'b00, 2, "glitch_a");
    add(1'b1, 2'b10, 2'b00, 2'b10, 1, "glitch_b");
    add(1'b1, 2'b00, 2'b00, 2'b10, 2, "glitch_c");
    add(1'b1, 2'b00, 2'b00, 2'b00, 3, "glitch_done");
    // both channels pressed together qualify independently
    add(1'b1, 2'b11, 2'b00, 2'b00, 2, "both_sync");
    add(1'b1, 2'b11, 2'b00, 2'b11, 4, "both_qual");
    add(1'b1, 2'b11, 2'b11, 2'b00, 1, "both_done");
    add(1'b1, 2'b10, 2'b11, 2'b00, 2, "ch0_rel_sync");
    add(1'b1, 2'b10, 2'b11, 2'b01, 4, "ch0_rel_qual");
    add(1'b1, 2'b10, 2'b10, 2'b00, 1, "ch0_rel_done");
    add(1'b1, 2'b00, 2'b10, 2'b00, 2, "ch1_rel_sync");
    add(1'b1, 2'b00, 2'b10, 2'b10, 4, "ch1_rel_qual");
    add(1'b1, 2'b00, 2'b00, 2'b00, 2, "ch1_rel_done");

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n   = vecs[i].rst_n;
      btn_raw = vecs[i].raw;
      tick();
      check(vecs[i].name, i, vecs[i].exp_db, vecs[i].exp_bn);
    end

    // 6. reset while ch0 is in S_RISE with cnt=2
    btn_raw = 2'b01;
    tick();                                   // edge k
    tick();                                   // k+1
    tick();                                   // k+2: S_RISE cnt0
    check("rst_mid_rise", 0, 2'b00, 2'b01);
    tick();                                   // k+3: cnt1
    tick();                                   // k+4: cnt2
    check("rst_mid_rise", 1, 2'b00, 2'b01);
    rst_n = 1'b0;
    tick();                                   // k+5: reset
    check("rst_mid_abort", 0, 2'b00, 2'b00);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin         // first post-reset sample at edge j
      tick();
      check("rst_post_sync", i, 2'b00, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_post_qual", i, 2'b00, 2'b01);
    end
    tick();                                   // j+6
    check("rst_post_done", 0, 2'b01, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
